fft_spectrum_buf: RTL and testbench

FFT_SPECTRUM_BUF -- requirements
Module: fft_spectrum_buf

---
 rtl/fft_spectrum_buf_if.sv | 26 ++
 rtl/fft_spectrum_buf.sv | 163 ++++++++++++++++
 tb/tb_fft_spectrum_buf.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_spectrum_buf_if.sv
// Bus bundle for fft_spectrum_buf: FFT magnitude input stream plus the
// LCD-side read request/response signals.
interface fft_spectrum_buf_if;
  logic        mag_valid;
  logic [15:0] mag_data;
  logic        mag_last;
  logic        frame_start;
  logic        data_req;
  logic        fft_point_done;
  logic [7:0]  fft_point_cnt;
  logic [7:0]  fft_data;
  logic        frame_drop;
  logic        frame_err;

  // Producer/display side (drives magnitudes and display requests)
  modport master (
    output mag_valid, mag_data, mag_last, frame_start, data_req, fft_point_done,
    input  fft_point_cnt, fft_data, frame_drop, frame_err
  );

  // Spectrum buffer side
  modport slave (
    input  mag_valid, mag_data, mag_last, frame_start, data_req, fft_point_done,
    output fft_point_cnt, fft_data, frame_drop, frame_err
  );
endinterface

// File: rtl/fft_spectrum_buf.sv
// fft_spectrum_buf: stores one 128-point spectrum (8-bit scaled magnitudes)
// for an LCD renderer. Optional macro FFT_SPEC_DBUF_EN enables a front/back
// double buffer that swaps only at LCD frame start; without it a single
// buffer is written and read directly (tearing allowed).
module fft_spectrum_buf #(
  parameter int MAG_SHIFT = 8
) (
  input logic              lcd_pclk,
  input logic              rst_n,
  fft_spectrum_buf_if.slave bus
);

`ifdef FFT_SPEC_DBUF_EN
  localparam int RAM_AW = 8;  // MSB selects the bank
  typedef enum logic {W_FILL, W_PEND} wstate_t;
`else
  localparam int RAM_AW = 7;
  typedef enum logic {W_FILL} wstate_t;
`endif

  logic [7:0]        r_mem [0:(1<<RAM_AW)-1];
  logic [7:0]        r_ram_q;
  wstate_t           r_state, w_state_next;
  logic [6:0]        r_wr_addr, w_wr_addr_next;
  logic              r_ovf, w_ovf_next;
  logic              w_we, w_err;
  logic              r_frame_err;
  logic [15:0]       w_shifted;
  logic [7:0]        w_point;
  logic [6:0]        r_cnt, w_cnt_next;
  logic              r_load, w_reload;
  logic [7:0]        r_fft_data;
  logic [RAM_AW-1:0] w_wr_ram_addr, w_rd_ram_addr;

  // Scale and saturate the incoming magnitude to one display point
  assign w_shifted = bus.mag_data >> MAG_SHIFT;
  assign w_point   = (|w_shifted[15:8]) ? 8'hFF : w_shifted[7:0];

`ifdef FFT_SPEC_DBUF_EN
  logic r_front, r_swap_d, w_swap, w_drop, r_frame_drop;
  assign w_wr_ram_addr = {~r_front, r_wr_addr};
  assign w_rd_ram_addr = {r_front, w_cnt_next};
  // A swap changes the bank under the reader, so reload one cycle later
  assign w_reload      = bus.data_req | bus.fft_point_done | r_swap_d;
  assign bus.frame_drop = r_frame_drop;

  // Bank select, delayed swap flag and drop pulse
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_front      <= 1'b0;
      r_swap_d     <= 1'b0;
      r_frame_drop <= 1'b0;
    end else begin
      if (w_swap) r_front <= ~r_front;
      r_swap_d     <= w_swap;
      r_frame_drop <= w_drop;
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok   = bus.frame_start;
  assign w_wr_ram_addr = r_wr_addr;
  assign w_rd_ram_addr = w_cnt_next;
  assign w_reload      = bus.data_req | bus.fft_point_done;
  assign bus.frame_drop = 1'b0;
`endif

  // Spectrum RAM: write port for the FFT side, registered read for display
  always_ff @(posedge lcd_pclk) begin
    if (w_we) r_mem[w_wr_ram_addr] <= w_point;
    r_ram_q <= r_mem[w_rd_ram_addr];
  end

  // Write FSM next-state: fill, frame-length checking, pending swap
  always_comb begin
    w_state_next   = r_state;
    w_wr_addr_next = r_wr_addr;
    w_ovf_next     = r_ovf;
    w_we           = 1'b0;
    w_err          = 1'b0;
`ifdef FFT_SPEC_DBUF_EN
    w_swap         = 1'b0;
    w_drop         = 1'b0;
`endif
    case (r_state)
      W_FILL: begin
        if (bus.mag_valid) begin
          if (r_ovf) begin
            // Over-long frame: drop samples until its mag_last arrives
            if (bus.mag_last) begin
              w_err          = 1'b1;
              w_wr_addr_next = '0;
              w_ovf_next     = 1'b0;
            end
          end else begin
            w_we = 1'b1;
            if (bus.mag_last) begin
              w_wr_addr_next = '0;
              w_err          = (r_wr_addr != 7'd127);
`ifdef FFT_SPEC_DBUF_EN
              if (r_wr_addr == 7'd127) w_state_next = W_PEND;
`endif
            end else if (r_wr_addr == 7'd127) begin
              w_ovf_next = 1'b1;
            end else begin
              w_wr_addr_next = r_wr_addr + 7'd1;
            end
          end
        end
      end
`ifdef FFT_SPEC_DBUF_EN
      W_PEND: begin
        if (bus.frame_start) begin
          w_swap       = 1'b1;
          w_state_next = W_FILL;
        end
        if (bus.mag_valid && bus.mag_last) w_drop = 1'b1;
      end
`endif
      default: w_state_next = W_FILL;
    endcase
  end

  // Write FSM state, write address and error pulse registers
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= W_FILL;
      r_wr_addr   <= '0;
      r_ovf       <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_wr_addr   <= w_wr_addr_next;
      r_ovf       <= w_ovf_next;
      r_frame_err <= w_err;
    end
  end

  // Read index: end-of-line wins over advance; advance saturates at 127
  always_comb begin
    w_cnt_next = r_cnt;
    if (bus.fft_point_done)                    w_cnt_next = '0;
    else if (bus.data_req && r_cnt != 7'd127)  w_cnt_next = r_cnt + 7'd1;
  end

  // Read index and output data; fft_data only changes on a reload
  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_load     <= 1'b0;
      r_fft_data <= '0;
    end else begin
      r_cnt  <= w_cnt_next;
      r_load <= w_reload;
      if (r_load) r_fft_data <= r_ram_q;
    end
  end

  assign bus.fft_point_cnt = {1'b0, r_cnt};
  assign bus.fft_data      = r_fft_data;
  assign bus.frame_err     = r_frame_err;

endmodule

// File: tb/tb_fft_spectrum_buf.sv
// Testbench for fft_spectrum_buf: two instances (MAG_SHIFT 8 and 0) share the
// same stimulus; a frame-level model predicts display contents and pulses.
module tb_fft_spectrum_buf;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_spectrum_buf_if if8();
  fft_spectrum_buf_if if0();

  fft_spectrum_buf #(.MAG_SHIFT(8)) dut8 (.lcd_pclk(clk), .rst_n(rst_n), .bus(if8));
  fft_spectrum_buf #(.MAG_SHIFT(0)) dut0 (.lcd_pclk(clk), .rst_n(rst_n), .bus(if0));

  int n_chk = 0;
  int n_pass = 0;
  int err8 = 0, err0 = 0, drop8 = 0, drop0 = 0;

  // model state
  int  mf[128];          // displayed frame (raw samples)
  int  mb[128];          // back frame (raw samples)
  bit  mpend = 1'b0;
  int  mcnt = 0;
  int  sh8 = 0, sh0 = 0; // value expected on fft_data
  int  xerr = 0, xdrop = 0;
  int  fbuf[256];

  typedef struct {
    bit req;
    bit done;
    int reps;
    int exp_cnt;
    int exp_d8;
    int exp_d0;
  } vec_t;
  vec_t tbl[11];

  // count pulse cycles
  always @(negedge clk) begin
    if (if8.frame_err === 1'b1)  err8++;
    if (if0.frame_err === 1'b1)  err0++;
    if (if8.frame_drop === 1'b1) drop8++;
    if (if0.frame_drop === 1'b1) drop0++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  function automatic int pt(input int raw, input int s);
    int v;
    v = raw >> s;
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic v, input logic l, input logic [15:0] d,
                       input logic fs, input logic rq, input logic dn);
    if8.mag_valid = v; if8.mag_last = l; if8.mag_data = d;
    if8.frame_start = fs; if8.data_req = rq; if8.fft_point_done = dn;
    if0.mag_valid = v; if0.mag_last = l; if0.mag_data = d;
    if0.frame_start = fs; if0.data_req = rq; if0.fft_point_done = dn;
  endtask

  task automatic send_frame(input int len);
    bit discard;
    discard = 1'b0;
`ifdef FFT_SPEC_DBUF_EN
    discard = mpend;
`endif
    if (discard) begin
      xdrop++;
    end else begin
      for (int i = 0; i < len && i < 128; i++) begin
`ifdef FFT_SPEC_DBUF_EN
        mb[i] = fbuf[i];
`else
        mf[i] = fbuf[i];
`endif
      end
      if (len == 128) begin
`ifdef FFT_SPEC_DBUF_EN
        mpend = 1'b1;
`endif
      end else begin
        xerr++;
      end
    end
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) step(1);
      drive(1'b1, (i == len - 1), fbuf[i][15:0], 1'b0, 1'b0, 1'b0);
      step(1);
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    end
    step(2);
  endtask

  task automatic pulse_fs();
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    step(1);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
`ifdef FFT_SPEC_DBUF_EN
    if (mpend) begin
      for (int i = 0; i < 128; i++) begin
        int t;
        t = mf[i]; mf[i] = mb[i]; mb[i] = t;
      end
      mpend = 1'b0;
      sh8 = pt(mf[mcnt], 8);
      sh0 = pt(mf[mcnt], 0);
    end
`endif
    step(3);
  endtask

  task automatic rd(input bit req, input bit done);
    drive(1'b0, 1'b0, 16'h0, 1'b0, req, done);
    step(1);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    if (done)     mcnt = 0;
    else if (req) mcnt = (mcnt < 127) ? mcnt + 1 : 127;
    sh8 = pt(mf[mcnt], 8);
    sh0 = pt(mf[mcnt], 0);
    step(2);
  endtask

  task automatic check_state(input string tag);
    chk({tag, " cnt8"},  if8.fft_point_cnt, mcnt);
    chk({tag, " cnt0"},  if0.fft_point_cnt, mcnt);
    chk({tag, " data8"}, if8.fft_data, sh8);
    chk({tag, " data0"}, if0.fft_data, sh0);
    chk({tag, " err8"},  err8, xerr);
    chk({tag, " err0"},  err0, xerr);
    chk({tag, " drop8"}, drop8, xdrop);
    chk({tag, " drop0"}, drop0, xdrop);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < 256; i++) fbuf[i] = v;
  endtask

  initial begin
    int act, len;
    for (int i = 0; i < 128; i++) begin mf[i] = 0; mb[i] = 0; end
    tbl[0]  = '{1'b0, 1'b1, 1,   0,   8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b0, 1,   1,   8'h01, 8'hFF};
    tbl[2]  = '{1'b1, 1'b0, 1,   2,   8'h00, 8'h02};
    tbl[3]  = '{1'b1, 1'b0, 5,   7,   8'h07, 8'hFF};
    tbl[4]  = '{1'b1, 1'b0, 120, 127, 8'h7F, 8'hFF};
    tbl[5]  = '{1'b1, 1'b0, 3,   127, 8'h7F, 8'hFF};
    tbl[6]  = '{1'b1, 1'b1, 1,   0,   8'h00, 8'h00};
    tbl[7]  = '{1'b1, 1'b0, 100, 100, 8'h00, 8'h64};
    tbl[8]  = '{1'b0, 1'b1, 1,   0,   8'h00, 8'h00};
    tbl[9]  = '{1'b1, 1'b0, 130, 127, 8'h7F, 8'hFF};
    tbl[10] = '{1'b1, 1'b1, 1,   0,   8'h00, 8'h00};

    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    step(3);
    rst_n = 1'b1;
    step(2);

    // partial frame interrupted by reset must be forgotten
    for (int i = 0; i < 50; i++) begin
      drive(1'b1, 1'b0, 16'hABCD, 1'b0, 1'b0, 1'b0);
      step(1);
    end
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(2);
    check_state("reset");
    chk("reset err_pin", if8.frame_err, 1'b0);
    chk("reset drop_pin", if8.frame_drop, 1'b0);

    // frame A: scaling and saturation
    fill(16'h1000);
    fbuf[5] = 16'h1234; fbuf[6] = 16'h0300; fbuf[7] = 16'h0042;
    send_frame(128);
    check_state("A_sent");
    pulse_fs();
    check_state("A_swap");
    for (int i = 0; i < 5; i++) rd(1'b1, 1'b0);
    check_state("A_idx5");
    chk("scale cnt", if8.fft_point_cnt, 8'd5);
    chk("scale data8", if8.fft_data, 8'h12);
    rd(1'b1, 1'b0);
    chk("sat data0", if0.fft_data, 8'hFF);
    chk("sat data8", if8.fft_data, 8'h03);
    rd(1'b1, 1'b0);
    chk("nosat data0", if0.fft_data, 8'h42);
    rd(1'b0, 1'b1);
    check_state("A_idx0");

    // frame B completes without frame_start
    fill(16'h2000);
    send_frame(128);
    check_state("B_sent");
    rd(1'b0, 1'b1);
    check_state("B_read");
`ifdef FFT_SPEC_DBUF_EN
    chk("dbuf hold", if8.fft_data, 8'h10);
`else
    chk("sbuf direct", if8.fft_data, 8'h20);
`endif

    // frame C arrives while B is pending
    fill(16'h3000);
    send_frame(128);
    check_state("C_sent");
`ifdef FFT_SPEC_DBUF_EN
    chk("drop once", drop8, 1);
`else
    chk("no drop", drop8, 0);
`endif
    pulse_fs();
    check_state("C_fs");
    rd(1'b0, 1'b1);
    check_state("C_read");
`ifdef FFT_SPEC_DBUF_EN
    chk("shows B", if8.fft_data, 8'h20);
`else
    chk("shows C", if8.fft_data, 8'h30);
`endif
    for (int i = 0; i < 3; i++) rd(1'b1, 1'b0);
    check_state("C_idx3");

    // short frame
    fill(16'h5000);
    send_frame(64);
    check_state("short");
    chk("short err", err8, 1);
    pulse_fs();
    check_state("short_fs");
`ifdef FFT_SPEC_DBUF_EN
    chk("short noswap", if8.fft_data, 8'h20);
`else
    chk("short noreload", if8.fft_data, 8'h30);
`endif

    // next full frame accepted normally
    fill(16'h4000);
    send_frame(128);
    pulse_fs();
    rd(1'b0, 1'b1);
    check_state("D_read");
    chk("D data8", if8.fft_data, 8'h40);

    // over-long frame
    fill(16'h6000);
    send_frame(131);
    check_state("long");
    pulse_fs();
    check_state("long_fs");

    // pattern frame for the read-side table
    for (int i = 0; i < 128; i++) fbuf[i] = (i % 2 == 1) ? (i << 8) : i;
    send_frame(128);
    pulse_fs();
    for (int v = 0; v < 11; v++) begin
      for (int r = 0; r < tbl[v].reps; r++) rd(tbl[v].req, tbl[v].done);
      chk($sformatf("tbl%0d cnt8", v),  if8.fft_point_cnt, tbl[v].exp_cnt);
      chk($sformatf("tbl%0d cnt0", v),  if0.fft_point_cnt, tbl[v].exp_cnt);
      chk($sformatf("tbl%0d data8", v), if8.fft_data, tbl[v].exp_d8);
      chk($sformatf("tbl%0d data0", v), if0.fft_data, tbl[v].exp_d0);
    end

    // randomized mix against the model
    for (int it = 0; it < 60; it++) begin
      act = $urandom_range(0, 9);
      if (act <= 2) begin
        len = $urandom_range(0, 9);
        if (len == 7)      len = $urandom_range(1, 127);
        else if (len == 8) len = $urandom_range(129, 140);
        else               len = 128;
        for (int i = 0; i < 256; i++)
          fbuf[i] = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 65535) : $urandom_range(0, 400);
        send_frame(len);
      end else if (act <= 4) begin
        pulse_fs();
      end else begin
        case ($urandom_range(0, 5))
          0:       rd(1'b0, 1'b1);
          1:       rd(1'b1, 1'b1);
          default: rd(1'b1, 1'b0);
        endcase
      end
      check_state($sformatf("rnd%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
